// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Purpose:
//   Control-side partner of the instruction decoder. Holds the instruction
//   register (opcode + operand) and the micro-step counter that index the
//   decoder, and consumes the decoder's II / ADV / HLT strobes. All control
//   word activity is qualified by o_en, which is derived from a small
//   RUN / PAUSE / HALT state machine plus a one-shot single-step grant.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_run          1 = free-run, 0 = pause (single-step mode)
//   i_step_req     debounced single-step button (level)
//   i_bus          shared data bus
//   i_instrregi    decoder II: load instruction register from the bus
//   i_adv          decoder ADV: end of instruction, step returns to 0
//   i_halt         decoder HLT
//   o_en           control-word qualifier (combinational from state/grant)
//   o_instruction  opcode to the decoder
//   o_operand      operand field of the instruction register
//   o_step         micro-step index to the decoder
//   o_halted       1 while halted
//   o_overrun      sticky: step counter wrapped without an ADV
//   o_retired      (SEQUENCER_RETIRE_COUNT_EN only) saturating count of
//                  retired instructions (enabled cycles with ADV)
//
// Configuration:
//   SEQUENCER_RETIRE_COUNT_EN  adds the o_retired port and its counter.
//                              Undefined by default; all other behaviour
//                              is identical either way.
// ---------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int INSTRUCTION_STEPS = 8,
    parameter int DATA_WIDTH        = 8,
    localparam int STEP_WIDTH    = (INSTRUCTION_STEPS > 1) ? $clog2(INSTRUCTION_STEPS) : 1,
    localparam int OPERAND_WIDTH = DATA_WIDTH - INSTRUCTION_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_run,
    input  logic                         i_step_req,
    input  logic [DATA_WIDTH-1:0]        i_bus,
    input  logic                         i_instrregi,
    input  logic                         i_adv,
    input  logic                         i_halt,
    output logic                         o_en,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [OPERAND_WIDTH-1:0]     o_operand,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_halted,
    output logic                         o_overrun
`ifdef SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [15:0]                  o_retired
`endif
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    logic   step_req_q;
    logic   step_grant;

    // The enable is the only combinational output: it must be usable by the
    // decoder in the same cycle the state / grant registers say so.
    assign o_en = (state == ST_RUN) | step_grant;

    // Run-control state machine. A halt strobe is only honoured when the
    // current cycle is enabled; once halted, only reset leaves HALT.
    // The single-step grant is a registered rising-edge detect on the
    // button, and it is only produced while paused so that presses made in
    // RUN or HALT never leave a stale step queued up.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_PAUSE;
            o_halted   <= 1'b0;
            step_req_q <= 1'b0;
            step_grant <= 1'b0;
        end else begin
            step_req_q <= i_step_req;
            step_grant <= (state == ST_PAUSE) & i_step_req & ~step_req_q;
            if (o_en && i_halt) begin
                state    <= ST_HALT;
                o_halted <= 1'b1;
            end else begin
                case (state)
                    ST_PAUSE: if (i_run)  state <= ST_RUN;
                    ST_RUN:   if (!i_run) state <= ST_PAUSE;
                    ST_HALT:  state <= ST_HALT;
                    default:  state <= ST_PAUSE;
                endcase
            end
        end
    end

    // Micro-step counter and instruction register. Nothing moves unless the
    // cycle is enabled. Halt freezes the step; ADV restarts it; running off
    // the end without ADV also restarts it but flags a sticky overrun.
    // The instruction load is independent of the step update so II and ADV
    // in the same cycle both take effect.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_step        <= '0;
            o_instruction <= '0;
            o_operand     <= '0;
            o_overrun     <= 1'b0;
        end else if (o_en) begin
            if (i_halt) begin
                o_step <= o_step;
            end else if (i_adv) begin
                o_step <= '0;
            end else if (o_step == LAST_STEP) begin
                o_step    <= '0;
                o_overrun <= 1'b1;
            end else begin
                o_step <= o_step + 1'b1;
            end
            if (i_instrregi) begin
                o_instruction <= i_bus[DATA_WIDTH-1 -: INSTRUCTION_WIDTH];
                o_operand     <= i_bus[OPERAND_WIDTH-1:0];
            end
        end
    end

`ifdef SEQUENCER_RETIRE_COUNT_EN
    // Retired-instruction counter: an enabled ADV that is not overridden by
    // a halt in the same cycle. Saturates rather than wrapping so a long run
    // never reads back as a small number.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_retired <= 16'h0000;
        end else if (o_en && i_adv && !i_halt && (o_retired != 16'hFFFF)) begin
            o_retired <= o_retired + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Purpose:
//   Self-checking bench for instruction_sequencer. A table of per-cycle
//   vectors covers fetch/decode/advance, simultaneous II+ADV, pausing with
//   step retention and ignored strobes while disabled. Hand-written
//   sequences cover single-stepping, halting, step overrun and an
//   asynchronous reset in the middle of an instruction.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

    logic       i_clk;
    logic       i_reset;
    logic       i_run;
    logic       i_step_req;
    logic [7:0] i_bus;
    logic       i_instrregi;
    logic       i_adv;
    logic       i_halt;
    logic       o_en;
    logic [3:0] o_instruction;
    logic [3:0] o_operand;
    logic [2:0] o_step;
    logic       o_halted;
    logic       o_overrun;
`ifdef SEQUENCER_RETIRE_COUNT_EN
    logic [15:0] o_retired;
`endif

    int checks;
    int failures;
    int en_count;

    typedef struct {
        logic       run;
        logic       step_req;
        logic [7:0] bus;
        logic       ii;
        logic       adv;
        logic       halt;
        logic       exp_en;
        logic [3:0] exp_instr;
        logic [3:0] exp_operand;
        logic [2:0] exp_step;
        logic       exp_halted;
        logic       exp_overrun;
    } vec_t;

    vec_t vectors[13];

    instruction_sequencer dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run         (i_run),
        .i_step_req    (i_step_req),
        .i_bus         (i_bus),
        .i_instrregi   (i_instrregi),
        .i_adv         (i_adv),
        .i_halt        (i_halt),
        .o_en          (o_en),
        .o_instruction (o_instruction),
        .o_operand     (o_operand),
        .o_step        (o_step),
        .o_halted      (o_halted),
        .o_overrun     (o_overrun)
`ifdef SEQUENCER_RETIRE_COUNT_EN
        ,
        .o_retired     (o_retired)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        i_run       = 1'b0;
        i_step_req  = 1'b0;
        i_bus       = 8'h00;
        i_instrregi = 1'b0;
        i_adv       = 1'b0;
        i_halt      = 1'b0;
    endtask

    // One clock edge, then settle just past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        i_reset = 1'b1;
        clearInputs();
        tick();
        i_reset = 1'b0;
    endtask

    // Drive a vector, check o_en for the cycle before the edge, then check
    // the registered outputs just after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        i_run       = v.run;
        i_step_req  = v.step_req;
        i_bus       = v.bus;
        i_instrregi = v.ii;
        i_adv       = v.adv;
        i_halt      = v.halt;
        #1;
        checkOutput($sformatf("v%0d_en", idx), 32'(o_en), 32'(v.exp_en));
        @(posedge i_clk);
        #1;
        checkOutput($sformatf("v%0d_instr", idx), 32'(o_instruction), 32'(v.exp_instr));
        checkOutput($sformatf("v%0d_operand", idx), 32'(o_operand), 32'(v.exp_operand));
        checkOutput($sformatf("v%0d_step", idx), 32'(o_step), 32'(v.exp_step));
        checkOutput($sformatf("v%0d_halted", idx), 32'(o_halted), 32'(v.exp_halted));
        checkOutput($sformatf("v%0d_overrun", idx), 32'(o_overrun), 32'(v.exp_overrun));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //                run sreq bus    ii adv hlt  en instr op  step hlt ovr
        vectors[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0};
        vectors[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd1, 1'b0, 1'b0};
        vectors[2]  = '{1'b1, 1'b0, 8'h1A, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'hA, 3'd2, 1'b0, 1'b0};
        vectors[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'hA, 3'd3, 1'b0, 1'b0};
        vectors[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'hA, 3'd4, 1'b0, 1'b0};
        vectors[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'hA, 3'd0, 1'b0, 1'b0};
        vectors[6]  = '{1'b1, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0};
        vectors[7]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 3'd1, 1'b0, 1'b0};
        vectors[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 3'd2, 1'b0, 1'b0};
        vectors[9]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 3'd2, 1'b0, 1'b0};
        vectors[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 3'd2, 1'b0, 1'b0};
        vectors[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 3'd2, 1'b0, 1'b0};
        vectors[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 3'd3, 1'b0, 1'b0};

        // Reset state
        i_reset = 1'b1;
        clearInputs();
        #12;
        checkOutput("reset_en", 32'(o_en), 32'd0);
        checkOutput("reset_instr", 32'(o_instruction), 32'd0);
        checkOutput("reset_operand", 32'(o_operand), 32'd0);
        checkOutput("reset_step", 32'(o_step), 32'd0);
        checkOutput("reset_halted", 32'(o_halted), 32'd0);
        checkOutput("reset_overrun", 32'(o_overrun), 32'd0);
        i_reset = 1'b0;

        // Fetch/advance, II+ADV together, pause and resume
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i], i);
        end

        // Single-step: three presses held five cycles each give three steps
        doReset();
        en_count = 0;
        for (int p = 0; p < 3; p++) begin
            i_step_req = 1'b1;
            for (int c = 0; c < 5; c++) begin
                en_count += int'(o_en);
                tick();
            end
            i_step_req = 1'b0;
            for (int c = 0; c < 3; c++) begin
                en_count += int'(o_en);
                tick();
            end
        end
        checkOutput("sstep_en_cycles", 32'(en_count), 32'd3);
        checkOutput("sstep_step", 32'(o_step), 32'd3);

        // Halt at step 2, then everything is ignored
        doReset();
        i_run = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("halt_pre_step", 32'(o_step), 32'd2);
        i_halt = 1'b1;
        #1;
        checkOutput("halt_pre_en", 32'(o_en), 32'd1);
        tick();
        i_halt = 1'b0;
        checkOutput("halt_halted", 32'(o_halted), 32'd1);
        checkOutput("halt_step", 32'(o_step), 32'd2);
        checkOutput("halt_en", 32'(o_en), 32'd0);
        en_count = 0;
        for (int c = 0; c < 8; c++) begin
            i_run       = c[1];
            i_step_req  = c[0];
            i_adv       = 1'b1;
            i_instrregi = 1'b1;
            i_bus       = 8'hC3;
            #1;
            en_count += int'(o_en);
            tick();
        end
        clearInputs();
        checkOutput("halt_en_cycles", 32'(en_count), 32'd0);
        checkOutput("halt_hold_step", 32'(o_step), 32'd2);
        checkOutput("halt_hold_instr", 32'(o_instruction), 32'd0);
        checkOutput("halt_hold_halted", 32'(o_halted), 32'd1);

        // Overrun: no ADV, step runs 1..7 then wraps to 0 and flags
        doReset();
        i_run = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("ovr_step_%0d", k), 32'(o_step), 32'(k % 8));
            checkOutput($sformatf("ovr_flag_%0d", k), 32'(o_overrun), (k == 8) ? 32'd1 : 32'd0);
        end
        i_adv = 1'b1;
        tick();
        i_adv = 1'b0;
        tick();
        tick();
        checkOutput("ovr_sticky", 32'(o_overrun), 32'd1);
        checkOutput("ovr_after_adv_step", 32'(o_step), 32'd2);

        // Asynchronous reset mid-instruction clears immediately
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("async_rst_step", 32'(o_step), 32'd0);
        checkOutput("async_rst_overrun", 32'(o_overrun), 32'd0);
        checkOutput("async_rst_en", 32'(o_en), 32'd0);
        tick();
        i_reset = 1'b0;
        clearInputs();

`ifdef SEQUENCER_RETIRE_COUNT_EN
        // Retire counter saturates and clears on reset
        doReset();
        i_run = 1'b1;
        i_adv = 1'b1;
        tick();
        for (int c = 0; c < 70000; c++) begin
            tick();
        end
        checkOutput("retired_sat", 32'(o_retired), 32'h0000FFFF);
        i_reset = 1'b1;
        #1;
        checkOutput("retired_reset", 32'(o_retired), 32'd0);
        tick();
        i_reset = 1'b0;
        clearInputs();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
